// File: rtl/fir_err_pkg.sv
// Shared types and width helpers for the FIR error-measurement stage.
package fir_err_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSkip  = 3'd1,
    StAcc   = 3'd2,
    StFlush = 3'd3,
    StDone  = 3'd4
  } err_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int diff_wl(input int w);
    return w + 1;
  endfunction

  function automatic int sq_wl(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int cnt_wl(input int skip_n, input int n_samples);
    return $clog2(max_int(skip_n, n_samples) + 1);
  endfunction

endpackage

// File: rtl/sat_acc.sv
// Unsigned accumulator that clamps to all-ones on overflow and remembers it in a sticky flag.
module sat_acc
  import fir_err_pkg::*;
#(
  parameter int IN_WL  = 34,
  parameter int ACC_WL = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [IN_WL-1:0]  din,
  output logic [ACC_WL-1:0] acc,
  output logic              sat
);

  // One spare bit above the wider operand catches the carry out of the ACC_WL-bit sum.
  localparam int SumWl = max_int(IN_WL, ACC_WL) + 1;

  logic [ACC_WL-1:0] acc_q, acc_d;
  logic              sat_q, sat_d;
  logic [SumWl-1:0]  sum;
  logic              ovf;

  always_comb begin
    sum   = SumWl'(acc_q) + SumWl'(din);
    ovf   = |sum[SumWl-1:ACC_WL];
    acc_d = acc_q;
    sat_d = sat_q;
    if (clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (en) begin
      if (ovf) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_WL-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc = acc_q;
  assign sat = sat_q;

endmodule

// File: rtl/fir_err_acc.sv
// Skips FIR fill samples, then accumulates sum of squared errors and peak |error| over one frame.
module fir_err_acc
  import fir_err_pkg::*;
#(
  parameter int DATA_INTE_WL = 4,
  parameter int DATA_FRAC_WL = 12,
  parameter int SKIP_N       = 30,
  parameter int N_SAMPLES    = 1024,
  parameter int ACC_WL       = 48
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic signed [DATA_INTE_WL+DATA_FRAC_WL-1:0] data_in,
  input  logic signed [DATA_INTE_WL+DATA_FRAC_WL-1:0] ref_in,
  input  logic                                        in_valid,
  output logic                                        busy,
  output logic                                        done,
  output logic [ACC_WL-1:0]                           err_sum,
  output logic [DATA_INTE_WL+DATA_FRAC_WL:0]          err_max,
  output logic                                        sat
);

  localparam int W  = DATA_INTE_WL + DATA_FRAC_WL;
  localparam int DW = diff_wl(W);
  localparam int SW = sq_wl(W);
  localparam int CW = cnt_wl(SKIP_N, N_SAMPLES);

  localparam logic [CW-1:0] SkipLast = CW'((SKIP_N > 0) ? SKIP_N - 1 : 0);
  localparam logic [CW-1:0] AccLast  = CW'(N_SAMPLES - 1);

  err_state_t    state_q, state_d;
  logic [CW-1:0] skip_cnt_q, skip_cnt_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_abs_q, s1_abs_d;
  logic [DW-1:0] err_max_q, err_max_d;
  logic [DW-1:0] diff;
  logic [SW-1:0] sq;
  logic          clr;
  logic          accept;

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    clr        = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          clr        = 1'b1;
          skip_cnt_d = '0;
          acc_cnt_d  = '0;
          state_d    = (SKIP_N == 0) ? StAcc : StSkip;
        end
      end
      StSkip: begin
        if (in_valid) begin
          skip_cnt_d = skip_cnt_q + 1'b1;
          if (skip_cnt_q == SkipLast) state_d = StAcc;
        end
      end
      StAcc: begin
        if (in_valid) begin
          accept    = 1'b1;
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (acc_cnt_q == AccLast) state_d = StFlush;
        end
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Stage 1: exact W+1 bit difference; negating -2^W still yields the right unsigned magnitude.
  always_comb begin
    diff       = {data_in[W-1], data_in} - {ref_in[W-1], ref_in};
    s1_abs_d   = diff[DW-1] ? (~diff + 1'b1) : diff;
    s1_valid_d = accept;
  end

  // Stage 2: square and peak tracking, both fed by the registered magnitude.
  always_comb begin
    sq        = SW'(s1_abs_q) * SW'(s1_abs_q);
    err_max_d = err_max_q;
    if (clr) begin
      err_max_d = '0;
    end else if (s1_valid_q && (s1_abs_q > err_max_q)) begin
      err_max_d = s1_abs_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      skip_cnt_q <= '0;
      acc_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_abs_q   <= '0;
      err_max_q  <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_abs_q   <= s1_abs_d;
      err_max_q  <= err_max_d;
    end
  end

  sat_acc #(
    .IN_WL  (SW),
    .ACC_WL (ACC_WL)
  ) u_sat_acc (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (s1_valid_q),
    .din (sq),
    .acc (err_sum),
    .sat (sat)
  );

  assign busy    = (state_q == StSkip) || (state_q == StAcc) || (state_q == StFlush);
  assign done    = (state_q == StDone);
  assign err_max = err_max_q;

endmodule

// File: doc/fir_err_acc.md
# fir_err_acc

Error-measurement stage downstream of the 30-tap FIR in the word-length optimisation flow. It consumes the FIR output stream (`data_out`/`out_valid`) together with a time-aligned golden reference sample. It discards the pipeline-fill samples, then accumulates the sum of squared errors and the peak absolute error over a fixed frame. The controller reads the results to score one fractional-word-length configuration.

## Interface
Parameters:
- `DATA_INTE_WL`, default 4: integer bits of the sample and reference.
- `DATA_FRAC_WL`, default 12: fractional bits of the sample and reference.
- `SKIP_N`, default 30: valid samples discarded after `start` (FIR fill).
- `N_SAMPLES`, default 1024: valid samples accumulated per frame; must be ≥1.
- `ACC_WL`, default 48: width of the squared-error accumulator.

Ports (W = `DATA_INTE_WL`+`DATA_FRAC_WL`):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle frame start pulse.
- `data_in` in W signed: FIR output sample.
- `ref_in` in W signed: golden sample, valid on the same cycle as `data_in`.
- `in_valid` in 1: qualifies `data_in` and `ref_in`.
- `busy` out 1: a frame is in progress.
- `done` out 1: results valid; held until the next accepted `start`.
- `err_sum` out `ACC_WL`: Σ(data_in−ref_in)², unsigned, LSB weight 2^(−2·`DATA_FRAC_WL`).
- `err_max` out W+1: max |data_in−ref_in|, unsigned.
- `sat` out 1: `err_sum` saturated during this frame.

## Operation
States: IDLE, SKIP, ACC, FLUSH, DONE.
- **IDLE**
  - `start` clears `err_sum`, `err_max`, `sat` and both counters.
  - Goes to SKIP, or directly to ACC if `SKIP_N`=0.
- **SKIP**
  - Each `in_valid` increments `skip_cnt`.
  - On the `SKIP_N`-th valid sample, goes to ACC. That sample is discarded.
- **ACC**
  - Each `in_valid` enters the arithmetic pipeline and increments `acc_cnt`.
  - On the `N_SAMPLES`-th valid sample, goes to FLUSH.
  - Valid samples arriving after that one are ignored.
- **FLUSH**: one cycle; the last product is accumulated. Then goes to DONE.
- **DONE**
  - `done`=1 and outputs are frozen.
  - `start` behaves exactly as it does in IDLE.
- `start` received in SKIP, ACC or FLUSH is ignored.
- Arithmetic:
  - Stage 1 registers diff = `data_in`−`ref_in` (W+1 bits signed, exact) and |diff| (W+1 bits unsigned). The valid flag is registered with them.
  - Stage 2 computes |diff|² (2W+2 bits) and adds it to `err_sum`. It also updates `err_max` = max(`err_max`, |diff|).
  - If the `ACC_WL`-bit addition overflows, `err_sum` is clamped to all-ones and `sat` is set; `sat` stays set until the next start.
  - |−2^W| = 2^W fits in W+1 bits unsigned.
- Reset mid-operation: the next edge forces IDLE and clears all outputs and pipeline valids. The aborted frame leaves no result.

## Timing
- Reset values: `busy`=0, `done`=0, `err_sum`=0, `err_max`=0, `sat`=0; state IDLE.
- `busy`=1 in SKIP, ACC and FLUSH, starting the cycle after `start`.
- `start` and the first valid sample may coincide.
  - In IDLE, that sample is not counted.
  - Counting begins the cycle after `start`.
- Latency from the last counted `in_valid` (edge k):
  - edge k+1: stage 1 registered.
  - edge k+2: accumulated; state leaves FLUSH.
  - `done`=1 is visible after edge k+2.
- `in_valid` may be deasserted for any number of cycles; the counters simply hold.
- Zero-bubble throughput: one sample per cycle.

## Structure
- Package `fir_err_pkg` contains:
  - the state enum `err_state_t` (IDLE, SKIP, ACC, FLUSH, DONE);
  - the width functions for W+1, 2W+2 and the counter width `$clog2(max(SKIP_N,N_SAMPLES)+1)`.
- One sub-module, `sat_acc`: an unsigned saturating accumulator.
  - Parameters: input width and `ACC_WL`.
  - Ports: `clk`, `rst`, `clr`, `en`, `din`, `acc`, `sat`.
- Control FSM, counters, stage 1 and the max tracker live in `fir_err_acc`.

## Test plan
- **Basic frame**: `SKIP_N`=2, `N_SAMPLES`=4, all defaults otherwise.
  - Stimulus: samples 0x0100 with ref 0x0100 (two skipped), then diffs +1, −1, +3, −2 LSB.
  - Required: `err_sum`=15, `err_max`=3, `sat`=0, `done` 2 cycles after the 4th counted sample.
- **Gapped valid**: same data with `in_valid` toggling 1-0-0-1.
  - Required: identical results; `busy` stays high through the gaps.
- **Extremes and saturation**, `ACC_WL`=34.
  - `data_in`=0x8000, `ref_in`=0x7FFF: diff −65535, `err_max`=65535.
  - With `N_SAMPLES`=8 of 0x8000 vs 0x7FFF: `sat`=1 and `err_sum`=2^34−1.
- **Ignored start**: second `start` pulse during ACC.
  - Required: no restart, counts unchanged.
  - A `start` in DONE clears the outputs and `busy` rises next cycle.
- **Reset mid-ACC**: `rst` after 2 of 4 samples.
  - Required: next cycle all outputs are 0 and state is IDLE.
  - A subsequent full frame yields the correct, uncontaminated sum.
- **`SKIP_N`=0, `N_SAMPLES`=1**: one sample with diff +5 immediately after `start`.
  - Required: `err_sum`=25, `err_max`=5.
